load_store_sched: RTL and testbench
===================================

// Module: load_store_sched
// PURPOSE
//  Scheduler for the shared volume counter between two requesters: a load (fill) port and a store (drain) port.
//  Each request names an amount; the granted transfer moves vol one unit per cycle until the amount is done or vol hits a bound.
//  Round-robin arbitration; one transfer at a time; req/gnt/done handshake per port.
//  Sits between the load/store traffic sources and the volume datapath; full replaces the old vol==N indicator.
// PARAMETERS
//  N      25000  upper bound of vol (full level); N < 2**CBITS
//  CBITS  15     width of vol, amounts and remaining-count
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      synchronous reset, ACTIVE-LOW (rst==0 at posedge resets)
//  fill_req   in   1      load requester wants a fill; hold until fill_gnt
//  fill_amt   in   CBITS  units to add; sampled in the cycle fill_gnt is issued
//  fill_gnt   out  1      1-cycle pulse: fill accepted, fill_amt captured
//  fill_done  out  1      1-cycle pulse: fill transfer finished
//  drain_req  in   1      store requester wants a drain; hold until drain_gnt
//  drain_amt  in   CBITS  units to remove; sampled with drain_gnt
//  drain_gnt  out  1      1-cycle pulse: drain accepted
//  drain_done out  1      1-cycle pulse: drain transfer finished
//  short      out  1      valid with *_done: 1 = stopped at bound before amount exhausted
//  vol        out  CBITS  current volume
//  full       out  1      registered, vol==N
//  empty      out  1      registered, vol==0
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst==0): state=IDLE, vol=0, rem=0, last=DRAIN (fill wins first tie), all gnt/done/short=0, full=0, empty=1, busy=0.
//  Reset mid-transfer aborts it: no done pulse, vol forced to 0.
//  FSM states IDLE, FILL, DRAIN; all outputs registered.
//  IDLE: at the posedge where a req is seen, move to FILL/DRAIN, pulse matching gnt, rem<=amt.
//   Both req: grant the port not served last (last flips on each grant); single req: grant it.
//   No req: stay IDLE; vol holds.
//  FILL, each posedge: if rem==0 or vol==N -> done pulse, short=(rem!=0), last=FILL, go IDLE;
//   else vol<=vol+1, rem<=rem-1.
//  DRAIN: mirror; bound is vol==0, vol<=vol-1.
//  Latency, no bound hit, amount k: gnt at edge 0, vol changes at edges 1..k, done at edge k+1, IDLE again after k+1;
//   earliest next gnt at edge k+2. amt=0: done at edge 1, short=0, vol unchanged.
//  A req arriving during a transfer waits; req is ignored while busy; gnt is never issued in the done cycle.
//  vol never wraps: never > N, never < 0 (saturating at both bounds by construction).
//  full/empty update on the same edge as vol (computed from the next value).
//  short deasserts the cycle after done; gnt and done of the same port never overlap.
// STRUCTURE
//  Package load_store_pkg: state enum {IDLE,FILL,DRAIN}, port enum for last, default N/CBITS localparams.
//  Sub-module vol_counter: CBITS up/down counter with inc/dec/clear inputs, bound N, outputs vol/full/empty.
//  Top holds the FSM, round-robin bit, rem register and handshake pulses.
// TESTING
//  Reset: rst=0 two cycles mid-fill (vol=5) -> vol=0, empty=1, busy=0, no fill_done.
//  Basic fill: fill_req, amt=3 from vol=0 -> gnt edge 0, vol 1,2,3, fill_done edge 4, short=0, busy low after.
//  Tie: fill_req and drain_req held together from reset -> fill granted first, drain next, alternating fairly.
//  Saturation: N=8, vol=6, fill amt=5 -> vol stops at 8, full=1, fill_done with short=1 after 2 increments.
//  Drain underflow: vol=2, drain amt=10 -> vol 1,0, empty=1, drain_done short=1; vol never wraps to 2**CBITS-1.
//  Zero amount + blocking: drain amt=0 -> done next edge, vol unchanged; fill_req asserted during a drain waits, no gnt until IDLE.

Source files
------------

// File: rtl/load_store_pkg.sv
// Shared types and default sizing for the load/store volume scheduler.
package load_store_pkg;

  localparam int N_DEF     = 25000;
  localparam int CBITS_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  typedef enum logic {
    PORT_FILL,
    PORT_DRAIN
  } port_t;

endpackage

// File: rtl/vol_counter.sv
// Saturating up/down volume counter bounded to [0, N] with registered full/empty flags.
module vol_counter #(
  parameter int N     = 25000,
  parameter int CBITS = 15
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CBITS-1:0] vol,
  output logic             full,
  output logic             empty
);

  localparam logic [CBITS-1:0] TOP = CBITS'(N);
  localparam logic [CBITS-1:0] ONE = CBITS'(1);

  logic [CBITS-1:0] vol_n;

  // Flags are derived from the next value so they move on the same edge as vol.
  always_comb begin
    vol_n = vol;
    if (clear) begin
      vol_n = '0;
    end else if (inc && (vol != TOP)) begin
      vol_n = vol + ONE;
    end else if (dec && (vol != '0)) begin
      vol_n = vol - ONE;
    end
  end

  always_ff @(posedge clk) begin
    vol   <= vol_n;
    full  <= (vol_n == TOP);
    empty <= (vol_n == '0);
  end

endmodule

// File: rtl/load_store_sched.sv
// Round-robin scheduler granting the shared volume counter to a fill port or a drain port,
// one transfer at a time, one unit per cycle.
module load_store_sched
  import load_store_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CBITS = CBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_req,
  input  logic [CBITS-1:0] fill_amt,
  output logic             fill_gnt,
  output logic             fill_done,
  input  logic             drain_req,
  input  logic [CBITS-1:0] drain_amt,
  output logic             drain_gnt,
  output logic             drain_done,
  output logic             short,
  output logic [CBITS-1:0] vol,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  // Handshake: a requester holds *_req until its 1-cycle *_gnt pulse, at which
  // edge *_amt is captured; requests are ignored while busy; *_done pulses once
  // when the transfer ends, with short valid in that same cycle only.

  state_t           state, state_n;
  port_t            last, last_n;
  logic [CBITS-1:0] rem, rem_n;
  logic             fill_gnt_n, drain_gnt_n, fill_done_n, drain_done_n, short_n;
  logic             inc, dec;

  always_comb begin
    state_n      = state;
    last_n       = last;
    rem_n        = rem;
    fill_gnt_n   = 1'b0;
    drain_gnt_n  = 1'b0;
    fill_done_n  = 1'b0;
    drain_done_n = 1'b0;
    short_n      = 1'b0;
    inc          = 1'b0;
    dec          = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port not served last wins.
        if (fill_req && (!drain_req || (last == PORT_DRAIN))) begin
          state_n    = FILL;
          fill_gnt_n = 1'b1;
          rem_n      = fill_amt;
          last_n     = PORT_FILL;
        end else if (drain_req) begin
          state_n     = DRAIN;
          drain_gnt_n = 1'b1;
          rem_n       = drain_amt;
          last_n      = PORT_DRAIN;
        end
      end
      FILL: begin
        if ((rem == '0) || full) begin
          fill_done_n = 1'b1;
          short_n     = (rem != '0);
          last_n      = PORT_FILL;
          state_n     = IDLE;
        end else begin
          inc   = 1'b1;
          rem_n = rem - CBITS'(1);
        end
      end
      DRAIN: begin
        if ((rem == '0) || empty) begin
          drain_done_n = 1'b1;
          short_n      = (rem != '0);
          last_n       = PORT_DRAIN;
          state_n      = IDLE;
        end else begin
          dec   = 1'b1;
          rem_n = rem - CBITS'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= PORT_DRAIN;
      rem        <= '0;
      fill_gnt   <= 1'b0;
      drain_gnt  <= 1'b0;
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      short      <= 1'b0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      rem        <= rem_n;
      fill_gnt   <= fill_gnt_n;
      drain_gnt  <= drain_gnt_n;
      fill_done  <= fill_done_n;
      drain_done <= drain_done_n;
      short      <= short_n;
    end
  end

  assign busy = (state != IDLE);

  vol_counter #(
    .N    (N),
    .CBITS(CBITS)
  ) u_vol (
    .clk  (clk),
    .clear(~rst),
    .inc  (inc),
    .dec  (dec),
    .vol  (vol),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_load_store_sched.sv
// Bench for load_store_sched: directed scenarios plus random traffic against a
// transaction-level model (grant edge, units moved, done edge).
module tb_load_store_sched;

  localparam int N     = 8;
  localparam int CBITS = 4;

  logic             clk;
  logic             rst;
  logic             fill_req, drain_req;
  logic [CBITS-1:0] fill_amt, drain_amt;
  logic             fill_gnt, fill_done, drain_gnt, drain_done;
  logic             short, full, empty, busy;
  logic [CBITS-1:0] vol;

  load_store_sched #(.N(N), .CBITS(CBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .fill_req  (fill_req),
    .fill_amt  (fill_amt),
    .fill_gnt  (fill_gnt),
    .fill_done (fill_done),
    .drain_req (drain_req),
    .drain_amt (drain_amt),
    .drain_gnt (drain_gnt),
    .drain_done(drain_done),
    .short     (short),
    .vol       (vol),
    .full      (full),
    .empty     (empty),
    .busy      (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model state: 0 = fill port, 1 = drain port
  int   t;
  int   m_vol;
  int   m_last;
  bit   m_act;
  int   m_port, m_g, m_amt, m_moved;
  bit   e_fg, e_dg, e_fd, e_dd, e_sh;
  logic [1:0] exp_q[$];

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One edge of the reference: a transfer of amount a on vol v moves
  // min(a, room) units, then finishes one edge later.
  task automatic model_edge();
    int pick;
    t++;
    e_fg = 0; e_dg = 0; e_fd = 0; e_dd = 0; e_sh = 0;
    if (!rst) begin
      m_vol  = 0;
      m_last = 1;
      m_act  = 0;
      exp_q.delete();
    end else if (m_act) begin
      if (t <= m_g + m_moved) begin
        m_vol += (m_port == 0) ? 1 : -1;
      end else begin
        if (m_port == 0) e_fd = 1; else e_dd = 1;
        e_sh  = (m_moved < m_amt);
        m_act = 0;
      end
    end else if (fill_req || drain_req) begin
      if (fill_req && drain_req) pick = (m_last == 1) ? 0 : 1;
      else                       pick = fill_req ? 0 : 1;
      m_port  = pick;
      m_amt   = (pick == 0) ? int'(fill_amt) : int'(drain_amt);
      m_moved = (pick == 0) ? min2(m_amt, N - m_vol) : min2(m_amt, m_vol);
      m_g     = t;
      m_last  = pick;
      m_act   = 1;
      if (pick == 0) e_fg = 1; else e_dg = 1;
      exp_q.push_back({pick[0], (m_moved < m_amt) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic compare();
    logic [1:0] ent;
    chk("vol",        int'(vol),        m_vol);
    chk("full",       int'(full),       int'(m_vol == N));
    chk("empty",      int'(empty),      int'(m_vol == 0));
    chk("busy",       int'(busy),       int'(m_act));
    chk("fill_gnt",   int'(fill_gnt),   int'(e_fg));
    chk("drain_gnt",  int'(drain_gnt),  int'(e_dg));
    chk("fill_done",  int'(fill_done),  int'(e_fd));
    chk("drain_done", int'(drain_done), int'(e_dd));
    chk("short",      int'(short),      int'(e_sh));
    if (fill_done || drain_done) begin
      if (exp_q.size() == 0) begin
        chk("done_without_grant", 1, 0);
      end else begin
        ent = exp_q.pop_front();
        chk("done_port_short", int'({drain_done, short}), int'(ent));
      end
    end
  endtask

  // driver: apply inputs (at a negedge), take one edge, check #1 later
  task automatic step(input bit r, input bit fr, input int fa, input bit dr, input int da);
    rst       = r;
    fill_req  = fr;
    fill_amt  = CBITS'(fa);
    drain_req = dr;
    drain_amt = CBITS'(da);
    @(posedge clk);
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  // hold requests until the model grants each one, then idle for extra cycles
  task automatic hold_until(input bit fr, input int fa, input bit dr, input int da, input int extra);
    bit fh, dh;
    int budget;
    fh = fr; dh = dr; budget = 60;
    while ((fh || dh) && budget > 0) begin
      step(1'b1, fh, fa, dh, da);
      if (e_fg) fh = 0;
      if (e_dg) dh = 0;
      budget--;
    end
    if (fh || dh) chk("grant_timeout", 1, 0);
    repeat (extra) step(1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    bit fh, dh;
    bit r;
    n_cmp = 0; n_err = 0; t = 0;
    m_vol = 0; m_last = 1; m_act = 0;
    m_port = 0; m_g = 0; m_amt = 0; m_moved = 0;

    // reset, then basic fill of 3 from empty
    step(1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    hold_until(1'b1, 3, 1'b0, 0, 6);

    // reset in the middle of a fill once vol has reached 5
    hold_until(1'b1, 10, 1'b0, 0, 2);
    chk("vol_before_reset", int'(vol), 5);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b0, 0, 1'b0, 0);

    // tie from reset: both held, grants must alternate starting with fill
    step(1'b0, 1'b0, 0, 1'b0, 0);
    repeat (24) step(1'b1, 1'b1, 1, 1'b1, 1);

    // saturation: vol 6, fill 5 stops at 8 with short
    step(1'b0, 1'b0, 0, 1'b0, 0);
    hold_until(1'b1, 6, 1'b0, 0, 8);
    hold_until(1'b1, 5, 1'b0, 0, 5);
    chk("sat_vol", int'(vol), N);

    // drain underflow: vol 2, drain 10 stops at 0 with short
    hold_until(1'b0, 0, 1'b1, 6, 8);
    hold_until(1'b0, 0, 1'b1, 10, 5);
    chk("underflow_vol", int'(vol), 0);

    // zero amount, then a fill request waiting behind a drain
    hold_until(1'b1, 4, 1'b0, 0, 6);
    hold_until(1'b0, 0, 1'b1, 0, 3);
    step(1'b1, 1'b0, 0, 1'b1, 3);
    hold_until(1'b1, 2, 1'b0, 0, 5);

    // random traffic with occasional reset
    fh = 0; dh = 0;
    repeat (3000) begin
      r = ($urandom_range(0, 299) != 0);
      if (!fh && $urandom_range(0, 3) == 0) fh = 1;
      if (!dh && $urandom_range(0, 3) == 0) dh = 1;
      step(r, fh, $urandom_range(0, 15), dh, $urandom_range(0, 15));
      if (e_fg) fh = 0;
      if (e_dg) dh = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
